// File: rtl/div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_unit                                                                 |
// | Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             sel_div,
   input  logic             sel_divu,
   input  logic             sel_rem,
   input  logic             sel_remu,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_want_rem;
   logic [WIDTH-1:0] r_result;

   logic             w_any_sel;
   logic             w_signed;
   logic             w_want_rem;
   logic             w_accept;
   logic             w_b_zero;
   logic             w_ovf;
   logic             w_special;
   logic [WIDTH-1:0] w_special_res;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_final;

   assign w_any_sel  = sel_div | sel_divu | sel_rem | sel_remu;
   assign w_signed   = sel_div | sel_rem;
   assign w_want_rem = sel_rem | sel_remu;
   // flush wins over a same-cycle start; starts during CALC are dropped
   assign w_accept   = start && w_any_sel && !flush && (r_state != S_CALC);

   assign w_b_zero  = (operand_b == '0);
   assign w_ovf     = w_signed && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
   assign w_special = w_b_zero | w_ovf;
   assign w_special_res = w_want_rem ? (w_b_zero ? operand_a : '0)
                                     : (w_b_zero ? '1 : operand_a);

   assign w_a_mag = (w_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
   assign w_b_mag = (w_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

   // One restoring step: shift in the next dividend bit, keep the difference if non-negative
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_diff     = w_shift - {1'b0, r_div};
   assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
   assign w_rem_next = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
   assign w_final    = r_want_rem ? (r_neg_r ? -w_rem_next : w_rem_next)
                                  : (r_neg_q ? -w_quo_next : w_quo_next);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            done = (r_state == S_DONE);
            if (w_accept) begin
               w_state_next = w_special ? S_DONE : S_CALC;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (flush) begin
               w_state_next = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_next = S_DONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_div      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_want_rem <= 1'b0;
         r_result   <= '0;
      end else if (w_accept) begin
         r_cnt      <= CNT_W'(WIDTH - 1);
         r_rem      <= '0;
         r_quo      <= w_a_mag;
         r_div      <= w_b_mag;
         r_neg_q    <= w_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
         r_neg_r    <= w_signed && operand_a[WIDTH-1];
         r_want_rem <= w_want_rem;
         if (w_special) begin
            r_result <= w_special_res;
         end
      end else if ((r_state == S_CALC) && !flush) begin
         r_rem <= w_rem_next;
         r_quo <= w_quo_next;
         if (r_cnt == '0) begin
            r_result <= w_final;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign result = r_result;

   a_onehot_sel: assert property (@(posedge clk) disable iff (!rst_n)
      start |-> $onehot0({sel_div, sel_divu, sel_rem, sel_remu}));

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_unit                                                              |
// | Directed vector table plus flush / reset / back-to-back sequences.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_div_unit;

   localparam int WIDTH = 32;
   // op select encoding: {div, divu, rem, remu}
   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_REM  = 4'b0010;
   localparam logic [3:0] OP_REMU = 4'b0001;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] operand_a = '0;
   logic [WIDTH-1:0] operand_b = '0;
   logic             sel_div = 1'b0;
   logic             sel_divu = 1'b0;
   logic             sel_rem = 1'b0;
   logic             sel_remu = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   div_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .flush     (flush),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .sel_div   (sel_div),
      .sel_divu  (sel_divu),
      .sel_rem   (sel_rem),
      .sel_remu  (sel_remu),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents an op in the current cycle; returns once done is seen (or timeout, lat=-1).
   // lat counts edges after the accepting edge; busy1 is busy just after acceptance.
   task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy1);
      {sel_div, sel_divu, sel_rem, sel_remu} = sel;
      operand_a = a;
      operand_b = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      {sel_div, sel_divu, sel_rem, sel_remu} = 4'b0000;
      operand_a = $urandom;
      operand_b = $urandom;
      busy1 = busy;
      lat = -1;
      for (int n = 0; n <= 100; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
      res = result;
   endtask

   vec_t        vecs[12];
   logic [31:0] res;
   logic [31:0] held;
   int          lat;
   logic        busy1;
   int          n_done;
   int          cyc;

   initial begin
      vecs[0]  = '{"div_pos_neg",   OP_DIV,  32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 32};
      vecs[1]  = '{"rem_pos_neg",   OP_REM,  32'd20,        32'hFFFFFFFD, 32'h00000002, 32};
      vecs[2]  = '{"divu_max_2",    OP_DIVU, 32'hFFFFFFFF,  32'd2,        32'h7FFFFFFF, 32};
      vecs[3]  = '{"remu_max_2",    OP_REMU, 32'hFFFFFFFF,  32'd2,        32'h00000001, 32};
      vecs[4]  = '{"rem_neg_pos",   OP_REM,  32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 32};
      vecs[5]  = '{"div_by_zero",   OP_DIV,  32'd7,         32'd0,        32'hFFFFFFFF, 0};
      vecs[6]  = '{"remu_by_zero",  OP_REMU, 32'd7,         32'd0,        32'h00000007, 0};
      vecs[7]  = '{"div_overflow",  OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 0};
      vecs[8]  = '{"rem_overflow",  OP_REM,  32'h80000000,  32'hFFFFFFFF, 32'h00000000, 0};
      vecs[9]  = '{"divu_100_7",    OP_DIVU, 32'd100,       32'd7,        32'd14,       32};
      vecs[10] = '{"div_neg_pos",   OP_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32};
      vecs[11] = '{"divu_ovf_pat",  OP_DIVU, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32};

      // reset state
      #12;
      check("reset_busy",   {31'b0, busy}, 32'd0);
      check("reset_done",   {31'b0, done}, 32'd0);
      check("reset_result", result,        32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat, busy1);
         check({vecs[i].name, "_result"}, res, vecs[i].exp);
         check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
         check({vecs[i].name, "_busy"}, {31'b0, busy1}, (vecs[i].lat != 0) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         check({vecs[i].name, "_done_pulse"}, {31'b0, done}, 32'd0);
         check({vecs[i].name, "_held"}, result, vecs[i].exp);
      end

      // flush mid-calculation: no done, result untouched, then a clean rerun
      held = result;
      {sel_div, sel_divu, sel_rem, sel_remu} = OP_DIVU;
      operand_a = 32'd100;
      operand_b = 32'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      {sel_div, sel_divu, sel_rem, sel_remu} = 4'b0000;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("flush_busy_before", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy_after", {31'b0, busy}, 32'd0);
      n_done = 0;
      for (int n = 0; n < 40; n++) begin
         if (done) n_done++;
         @(posedge clk); #1;
      end
      check("flush_no_done", n_done, 32'd0);
      check("flush_result_held", result, held);
      run_op(OP_DIVU, 32'd100, 32'd7, res, lat, busy1);
      check("after_flush_result", res, 32'd14);
      check("after_flush_latency", lat, 32'd32);

      // back-to-back: normal op started in the DONE cycle, then special case in its DONE cycle
      run_op(OP_REMU, 32'd100, 32'd7, res, lat, busy1);
      check("b2b_first_result", res, 32'd2);
      run_op(OP_DIV, 32'd20, 32'hFFFFFFFD, res, lat, busy1);
      check("b2b_no_gap_busy", {31'b0, busy1}, 32'd1);
      check("b2b_second_result", res, 32'hFFFFFFFA);
      check("b2b_second_latency", lat, 32'd32);
      run_op(OP_DIV, 32'd7, 32'd0, res, lat, busy1);
      check("b2b_special_latency", lat, 32'd0);
      check("b2b_special_result", res, 32'hFFFFFFFF);
      @(posedge clk); #1;

      // start while busy is ignored; the original op completes on schedule
      {sel_div, sel_divu, sel_rem, sel_remu} = OP_DIVU;
      operand_a = 32'd100;
      operand_b = 32'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      {sel_div, sel_divu, sel_rem, sel_remu} = OP_DIV;
      operand_a = 32'd20;
      operand_b = 32'hFFFFFFFD;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      {sel_div, sel_divu, sel_rem, sel_remu} = 4'b0000;
      cyc = -1;
      for (int n = 4; n <= 100; n++) begin
         if (done) begin
            cyc = n;
            break;
         end
         @(posedge clk); #1;
      end
      check("ignored_start_latency", cyc, 32'd32);
      check("ignored_start_result", result, 32'd14);
      @(posedge clk); #1;

      // asynchronous reset in the middle of a calculation
      run_op(OP_DIVU, 32'hFFFFFFFF, 32'd2, res, lat, busy1);
      {sel_div, sel_divu, sel_rem, sel_remu} = OP_DIVU;
      operand_a = 32'd100;
      operand_b = 32'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      {sel_div, sel_divu, sel_rem, sel_remu} = 4'b0000;
      repeat (5) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_busy",   {31'b0, busy}, 32'd0);
      check("async_rst_done",   {31'b0, done}, 32'd0);
      check("async_rst_result", result,        32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(OP_REM, 32'hFFFFFFEC, 32'd3, res, lat, busy1);
      check("post_rst_result", res, 32'hFFFFFFFE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
